meas_arbiter: RTL

MEAS_ARBITER -- requirements
Module: meas_arbiter

---
 rtl/meas_pkg.sv | 21 ++
 rtl/meas_arbiter_rr.sv | 36 +++
 rtl/meas_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/meas_pkg.sv
// Shared definitions for the measurement arbiter: FSM encoding, result width
// and a helper that sizes the internal cycle counters.
package meas_pkg;

  localparam int RESULT_W = 22;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_START   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_ACK     = 3'd5
  } state_t;

  // Bits needed to hold any value in 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/meas_arbiter_rr.sv
// Combinational round-robin picker: the first requesting channel found when
// scanning upward from ptr, wrapping at N_CH.
module rr_arbiter #(
  parameter  int N_CH  = 4,
  localparam int IDX_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_CH-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  int               ch;
  logic [IDX_W-1:0] pos;
  logic             found;

  // Scan all channels starting at ptr and keep the first hit.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    ch      = 0;
    pos     = '0;
    for (int i = 0; i < N_CH; i++) begin
      ch = int'(ptr) + i;
      if (ch >= N_CH) ch = ch - N_CH;
      pos = IDX_W'(ch);
      if (!found && req[pos]) begin
        found    = 1'b1;
        gnt[pos] = 1'b1;
        gnt_idx  = pos;
      end
    end
  end

endmodule

// File: rtl/meas_arbiter.sv
// Arbitrates N_CH channels onto one shared AD mux and energy-measurement unit.
//
// state   | meaning
// IDLE    | waiting for any req, round-robin grant
// SETTLE  | mux switched, waiting SETTLE_CYC cycles for the input to settle
// START   | meas_start pulse to the measurement unit
// WAIT    | waiting for meas_done, bounded by TIMEOUT_CYC
// CAPTURE | meas_data valid, load result
// ACK     | ack pulse to the served channel, advance round-robin pointer
module meas_arbiter
  import meas_pkg::*;
#(
  parameter  int N_CH        = 4,
  parameter  int SETTLE_CYC  = 16,
  parameter  int TIMEOUT_CYC = 1048575,
  localparam int IDX_W       = $clog2(N_CH)
) (
  input  logic                clk_sys,
  input  logic                rst_n,
  input  logic [N_CH-1:0]     req,
  output logic [N_CH-1:0]     ack,
  output logic [RESULT_W-1:0] result,
  output logic [IDX_W-1:0]    result_ch,
  output logic                result_err,
  output logic                busy,
  output logic [IDX_W-1:0]    ad_sel,
  output logic                meas_start,
  input  logic                meas_done,
  input  logic [RESULT_W-1:0] meas_data
);

  localparam int ST_W = cnt_width(SETTLE_CYC);
  localparam int TO_W = cnt_width(TIMEOUT_CYC);
  localparam logic [ST_W-1:0]  SETTLE_LAST  = ST_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
  localparam logic [TO_W-1:0]  TIMEOUT_LAST = TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_CH      = IDX_W'(N_CH - 1);

  state_t           state;
  logic [ST_W-1:0]  settle_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [IDX_W-1:0] rr_ptr;
  logic [N_CH-1:0]  gnt_oh;
  logic [N_CH-1:0]  arb_gnt;
  logic [IDX_W-1:0] arb_idx;

  rr_arbiter #(.N_CH(N_CH)) u_rr (
    .req     (req),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  // ad_sel doubles as the granted index: it is only ever loaded at grant.
  assign busy = (state != ST_IDLE);

  // Sequencing FSM; all outputs except busy are registered here.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      to_cnt     <= '0;
      rr_ptr     <= '0;
      gnt_oh     <= '0;
      ad_sel     <= '0;
      ack        <= '0;
      meas_start <= 1'b0;
      result     <= '0;
      result_ch  <= '0;
      result_err <= 1'b0;
    end else begin
      meas_start <= 1'b0;
      ack        <= '0;
      case (state)
        ST_IDLE: begin
          if (|arb_gnt) begin
            ad_sel     <= arb_idx;
            gnt_oh     <= arb_gnt;
            settle_cnt <= '0;
            if (SETTLE_CYC == 0) begin
              meas_start <= 1'b1;
              state      <= ST_START;
            end else begin
              state <= ST_SETTLE;
            end
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            meas_start <= 1'b1;
            state      <= ST_START;
          end else begin
            settle_cnt <= settle_cnt + ST_W'(1);
          end
        end
        ST_START: begin
          to_cnt <= '0;
          state  <= ST_WAIT;
        end
        ST_WAIT: begin
          // A done arriving in the terminal cycle still wins over the timeout.
          if (meas_done) begin
            state <= ST_CAPTURE;
          end else if (to_cnt == TIMEOUT_LAST) begin
            result     <= '0;
            result_err <= 1'b1;
            result_ch  <= ad_sel;
            ack        <= gnt_oh;
            state      <= ST_ACK;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        ST_CAPTURE: begin
          result     <= meas_data;
          result_err <= 1'b0;
          result_ch  <= ad_sel;
          ack        <= gnt_oh;
          state      <= ST_ACK;
        end
        ST_ACK: begin
          rr_ptr <= (ad_sel == LAST_CH) ? '0 : ad_sel + IDX_W'(1);
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
